// File: rtl/lcd_ctrl_pkg.sv
// Shared types and address helper for the parametrised LCD image controller.
package lcd_ctrl_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE  = 4'h0,
        CMD_UP     = 4'h1,
        CMD_DOWN   = 4'h2,
        CMD_LEFT   = 4'h3,
        CMD_RIGHT  = 4'h4,
        CMD_MAX    = 4'h5,
        CMD_MIN    = 4'h6,
        CMD_AVG    = 4'h7,
        CMD_ROTCCW = 4'h8,
        CMD_ROTCW  = 4'h9,
        CMD_MIRX   = 4'hA,
        CMD_MIRY   = 4'hB
    } cmd_e;

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        EXEC,
        WRITE,
        FIN
    } state_e;

    // Row-major buffer address of window cell (r,c) around operation point (x,y).
    function automatic int win_idx(input int x, input int y, input int r, input int c,
                                   input int win, input int img_w);
        return (y - win / 2 + r) * img_w + (x - win / 2 + c);
    endfunction

endpackage

// File: rtl/lcd_win_reduce.sv
// Combinational max / min / sum over all pixels of the operation window.
module lcd_win_reduce #(
    parameter int DW  = 8,
    parameter int WIN = 4,
    parameter int SW  = DW + 2 * $clog2(WIN)
) (
    input  logic [DW-1:0] pix [WIN*WIN],
    output logic [DW-1:0] pix_max,
    output logic [DW-1:0] pix_min,
    output logic [SW-1:0] pix_sum
);

    // Fold every window pixel into the running max, min and sum.
    always_comb begin
        pix_max = pix[0];
        pix_min = pix[0];
        pix_sum = '0;
        for (int i = 0; i < WIN * WIN; i++) begin
            if (pix[i] > pix_max) pix_max = pix[i];
            if (pix[i] < pix_min) pix_min = pix[i];
            pix_sum = pix_sum + SW'(pix[i]);
        end
    end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// LCD image controller: loads an image from IROM, applies window commands,
// then streams the buffer to IRAM and parks in FIN with done raised.
//
// state | meaning
// LOAD  | reading IROM into the buffer (IROM_rd high for N cycles)
// IDLE  | waiting for a command, busy=0
// EXEC  | one-cycle window / point command
// WRITE | streaming buffer to IRAM, one pixel per cycle
// FIN   | image written, done=1 until reset
module lcd_ctrl_gen
    import lcd_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int WIN   = 4,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    input  logic [DW-1:0] IROM_Q,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int NW = WIN * WIN;
    localparam int LW = $clog2(WIN);
    localparam int SW = DW + 2 * LW;
    localparam int XW = $clog2(IMG_W) + 1;
    localparam int YW = $clog2(IMG_H) + 1;
    localparam logic [AW:0] N_CNT = (AW + 1)'(N);

    state_e        state;
    logic [3:0]    cmd_q;
    logic [XW-1:0] pt_x;
    logic [YW-1:0] pt_y;
    logic [AW:0]   wr_cnt;

    logic [DW-1:0] buf_mem  [N];
    logic [AW-1:0] win_addr [NW];
    logic [DW-1:0] win_pix  [NW];
    logic [DW-1:0] new_pix  [NW];
    logic [DW-1:0] win_max;
    logic [DW-1:0] win_min;
    logic [SW-1:0] win_sum;
    logic [DW-1:0] win_avg;

    for (genvar gr = 0; gr < WIN; gr++) begin : g_row
        for (genvar gc = 0; gc < WIN; gc++) begin : g_col
            assign win_addr[gr*WIN+gc] = AW'(win_idx(int'(pt_x), int'(pt_y), gr, gc, WIN, IMG_W));
            assign win_pix[gr*WIN+gc]  = buf_mem[win_addr[gr*WIN+gc]];
        end
    end

    lcd_win_reduce #(
        .DW (DW),
        .WIN(WIN),
        .SW (SW)
    ) u_reduce (
        .pix    (win_pix),
        .pix_max(win_max),
        .pix_min(win_min),
        .pix_sum(win_sum)
    );

    // Power-of-two window area makes the average a plain right shift.
    assign win_avg = DW'(win_sum >> (2 * LW));

    // New window contents for the latched command; non-window commands pass pixels through.
    always_comb begin
        for (int i = 0; i < NW; i++) new_pix[i] = win_pix[i];
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                case (cmd_q)
                    CMD_MAX:    new_pix[r*WIN+c] = win_max;
                    CMD_MIN:    new_pix[r*WIN+c] = win_min;
                    CMD_AVG:    new_pix[r*WIN+c] = win_avg;
                    CMD_ROTCCW: new_pix[r*WIN+c] = win_pix[c*WIN+(WIN-1-r)];
                    CMD_ROTCW:  new_pix[r*WIN+c] = win_pix[(WIN-1-c)*WIN+r];
                    CMD_MIRX:   new_pix[r*WIN+c] = win_pix[(WIN-1-r)*WIN+c];
                    CMD_MIRY:   new_pix[r*WIN+c] = win_pix[r*WIN+(WIN-1-c)];
                    default:    new_pix[r*WIN+c] = win_pix[r*WIN+c];
                endcase
            end
        end
    end

    // Image buffer: filled from IROM during LOAD, window written back on every EXEC.
    always_ff @(posedge clk) begin
        if (state == LOAD && IROM_rd) begin
            buf_mem[IROM_A] <= IROM_Q;
        end else if (state == EXEC) begin
            for (int i = 0; i < NW; i++) buf_mem[win_addr[i]] <= new_pix[i];
        end
    end

    // Control FSM with registered interface outputs and operation point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LOAD;
            cmd_q      <= '0;
            pt_x       <= XW'(IMG_W / 2);
            pt_y       <= YW'(IMG_H / 2);
            wr_cnt     <= '0;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (!IROM_rd) begin
                        IROM_rd <= 1'b1;
                        IROM_A  <= '0;
                    end else if (IROM_A == AW'(N - 1)) begin
                        IROM_rd <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        IROM_A <= IROM_A + 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q  <= cmd;
                        busy   <= 1'b1;
                        wr_cnt <= '0;
                        state  <= (cmd == CMD_WRITE) ? WRITE : EXEC;
                    end
                end
                EXEC: begin
                    case (cmd_q)
                        CMD_UP:    if (pt_y > YW'(WIN / 2))         pt_y <= pt_y - YW'(1);
                        CMD_DOWN:  if (pt_y < YW'(IMG_H - WIN / 2)) pt_y <= pt_y + YW'(1);
                        CMD_LEFT:  if (pt_x > XW'(WIN / 2))         pt_x <= pt_x - XW'(1);
                        CMD_RIGHT: if (pt_x < XW'(IMG_W - WIN / 2)) pt_x <= pt_x + XW'(1);
                        default: ;
                    endcase
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                WRITE: begin
                    if (wr_cnt < N_CNT) begin
                        IRAM_valid <= 1'b1;
                        IRAM_A     <= wr_cnt[AW-1:0];
                        IRAM_D     <= buf_mem[wr_cnt[AW-1:0]];
                        wr_cnt     <= wr_cnt + 1'b1;
                    end else begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= FIN;
                    end
                end
                FIN: ;
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen: ramp image through 8x8/WIN4 and 16x16/WIN8 instances.
module tb_lcd_ctrl_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8x8, WIN=4 instance
    logic       reset, cmd_valid, IROM_rd, IRAM_valid, busy, done;
    logic [3:0] cmd;
    logic [5:0] IROM_A, IRAM_A;
    logic [7:0] IROM_Q, IRAM_D;

    // 16x16, WIN=8 instance
    logic       reset16, cmd_valid16, IROM_rd16, IRAM_valid16, busy16, done16;
    logic [3:0] cmd16;
    logic [7:0] IROM_A16, IRAM_A16;
    logic [7:0] IROM_Q16, IRAM_D16;

    logic [7:0] rom8 [64];
    logic [7:0] ram8 [64];
    logic [7:0] rom16 [256];
    logic [7:0] ram16 [256];

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int rd_cnt = 0;

    lcd_ctrl_gen dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
        .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
        .busy(busy), .done(done)
    );

    lcd_ctrl_gen #(.IMG_W(16), .IMG_H(16), .DW(8), .WIN(8)) dut16 (
        .clk(clk), .reset(reset16), .cmd(cmd16), .cmd_valid(cmd_valid16),
        .IROM_rd(IROM_rd16), .IROM_A(IROM_A16), .IROM_Q(IROM_Q16),
        .IRAM_valid(IRAM_valid16), .IRAM_D(IRAM_D16), .IRAM_A(IRAM_A16),
        .busy(busy16), .done(done16)
    );

    // ROM/RAM models act on the falling edge
    always @(negedge clk) begin
        if (IROM_rd) IROM_Q <= rom8[IROM_A];
        if (IRAM_valid) begin
            ram8[IRAM_A] <= IRAM_D;
            vcnt = vcnt + 1;
        end
        if (IROM_rd16) IROM_Q16 <= rom16[IROM_A16];
        if (IRAM_valid16) ram16[IRAM_A16] <= IRAM_D16;
    end

    typedef struct packed {
        logic [31:0]     cmds;
        logic [3:0]      n;
        logic [3:0][7:0] addr;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic [31:0] c, input int n,
                                input int a0, input int e0, input int a1, input int e1,
                                input int a2, input int e2, input int a3, input int e3);
        vec_t v;
        v.cmds = c;
        v.n    = 4'(n);
        v.addr = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        v.exp  = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit check_out);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        if (check_out) begin
            chk("rst_busy", int'(busy), 1);
            chk("rst_done", int'(done), 0);
            chk("rst_rom_rd", int'(IROM_rd), 0);
            chk("rst_ram_valid", int'(IRAM_valid), 0);
            chk("rst_rom_a", int'(IROM_A), 0);
            chk("rst_ram_a", int'(IRAM_A), 0);
            chk("rst_ram_d", int'(IRAM_D), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // junk>0 drives a MAX command during the first cycles of LOAD; it must be ignored
    task automatic load_wait(input int junk);
        rd_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (k < junk) begin
                cmd       = 4'h5;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (k == 0) begin
                chk("load_first_rd", int'(IROM_rd), 1);
                chk("load_first_a", int'(IROM_A), 0);
            end
            if (IROM_rd) rd_cnt++;
            if (!busy) break;
        end
        cmd_valid = 1'b0;
        chk("load_rd_cycles", rd_cnt, 64);
        chk("load_busy_low", int'(busy), 0);
    endtask

    task automatic send_cmd(input logic [3:0] c, output int bc);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        bc = 0;
        for (int k = 0; k < 8 && busy; k++) begin
            bc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic write_and_wait();
        for (int a = 0; a < 64; a++) ram8[a] = 8'hEE;
        vcnt      = 0;
        cmd       = 4'h0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        chk("wr_done", int'(done), 1);
        chk("wr_valid_cycles", vcnt, 64);
        chk("wr_busy_fin", int'(busy), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int bc;
        do_reset(1'b0);
        load_wait(0);
        for (int i = 0; i < int'(v.n); i++) begin
            send_cmd(v.cmds[4*i +: 4], bc);
            chk($sformatf("v%0d_busy_cycles_%0d", idx, i), bc, 1);
        end
        write_and_wait();
        for (int j = 0; j < 4; j++)
            chk($sformatf("v%0d_ram[%0d]", idx, int'(v.addr[j])),
                int'(ram8[v.addr[j][5:0]]), int'(v.exp[j]));
    endtask

    initial begin
        int sent_vcnt;
        reset       = 1'b0;
        cmd         = 4'h0;
        cmd_valid   = 1'b0;
        reset16     = 1'b0;
        cmd16       = 4'h0;
        cmd_valid16 = 1'b0;
        for (int a = 0; a < 64; a++) rom8[a] = 8'(a);
        for (int a = 0; a < 256; a++) begin
            rom16[a] = 8'(a);
            ram16[a] = 8'hEE;
        end

        vecs[0] = mk(32'h0,        0,  0, 0, 27, 27, 63, 63, 36, 36);
        vecs[1] = mk(32'h5,        1, 18, 45, 45, 45, 27, 45, 17, 17);
        vecs[2] = mk(32'h07111333, 7,  0, 13, 27, 13, 28, 28, 32, 32);
        vecs[3] = mk(32'h9,        1, 18, 42, 21, 18, 45, 21, 42, 45);
        vecs[4] = mk(32'hBEA,      3, 18, 45, 45, 18, 21, 42, 42, 21);
        vecs[5] = mk(32'h6,        1, 45, 18, 26, 18, 46, 46, 18, 18);
        vecs[6] = mk(32'h08222444, 7, 36, 39, 63, 60, 39, 63, 60, 36);
        vecs[7] = mk(32'hA,        1, 18, 42, 42, 18, 21, 45,  0,  0);
        vecs[8] = mk(32'h52222,    5, 34, 61, 61, 61, 33, 33, 62, 62);

        // Reset values, ignored command during LOAD, full ramp write
        do_reset(1'b1);
        load_wait(6);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_no_write", int'(IRAM_valid), 0);
        write_and_wait();
        for (int a = 0; a < 64; a++) chk($sformatf("ramp_ram[%0d]", a), int'(ram8[a]), a);

        // FIN ignores further commands
        sent_vcnt = vcnt;
        cmd       = 4'h0;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("fin_done", int'(done), 1);
        chk("fin_busy", int'(busy), 1);
        chk("fin_no_rewrite", vcnt, sent_vcnt);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset during WRITE at pixel 30
        do_reset(1'b0);
        load_wait(0);
        cmd       = 4'h0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (IRAM_valid && IRAM_A == 6'd30) break;
            @(posedge clk); #1;
        end
        chk("mw_reached_30", int'(IRAM_A), 30);
        reset = 1'b0;
        #1;
        chk("mw_done", int'(done), 0);
        chk("mw_busy", int'(busy), 1);
        chk("mw_valid", int'(IRAM_valid), 0);
        chk("mw_ram_d", int'(IRAM_D), 0);
        chk("mw_ram_a", int'(IRAM_A), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        load_wait(0);
        run_vec(vecs[1], 9);

        // 16x16 image, WIN=8: ramp and write
        @(posedge clk); #1;
        reset16 = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (!busy16) break;
        end
        chk("big_load_done", int'(busy16), 0);
        cmd16       = 4'h0;
        cmd_valid16 = 1'b1;
        @(posedge clk); #1;
        cmd_valid16 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (done16) break;
            @(posedge clk); #1;
        end
        chk("big_done", int'(done16), 1);
        for (int a = 0; a < 256; a++) chk($sformatf("big_ram[%0d]", a), int'(ram16[a]), a % 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
